// File: rtl/mdsa_stream_ctrl.sv
// Stream packer/sequencer/unpacker wrapped around the 8x8 odd-even MDSA sorter core.
// Optional sort-phase cycle counter: define MDSA_STREAM_CTRL_CYCLE_CNT_EN.
`timescale 1ns/1ps
module mdsa_stream_ctrl #(
    parameter int N        = 8,
    parameter int DW       = 32,
    parameter int PASSES   = 4,
    parameter int SORT_LAT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    output logic [N*N*DW-1:0] frame_out,
    output logic              sort_en,
    output logic              sort_start,
    output logic              sort_trans,
    output logic [N-1:0]      sort_dir,
    input  logic [N*N*DW-1:0] frame_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_data,
    output logic              m_last,
    output logic              busy
`ifdef MDSA_STREAM_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]       sort_cycles
`endif
);

    localparam int NN  = N * N;
    localparam int WCW = $clog2(NN);
    localparam logic [WCW-1:0] WLAST     = WCW'(NN - 1);
    localparam logic [7:0]     WAIT_LAST = 8'(SORT_LAT - 1);
    localparam logic [3:0]     PASS_LAST = 4'(PASSES);

    function automatic logic [N-1:0] snake_pattern();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = ((i % 2) == 1);
        return p;
    endfunction

    localparam logic [N-1:0] SNAKE = snake_pattern();

    typedef enum logic [2:0] {IDLE, LOAD, PRIME, SORT, SETTLE, DRAIN} state_t;

    state_t          state, state_nx;
    logic [WCW-1:0]  wcnt, wcnt_nx;
    logic [3:0]      pass_cnt, pass_nx;
    logic [7:0]      wait_cnt, wait_nx;
    logic [NN*DW-1:0] cap_buf;
    logic            s_hs, m_hs, capture, trans_nx, ready_nx;

    assign s_hs = s_valid && s_ready;
    assign m_hs = m_valid && m_ready;

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        pass_nx  = pass_cnt;
        wait_nx  = wait_cnt;
        capture  = 1'b0;
        case (state)
            IDLE, LOAD: begin
                if (s_hs) begin
                    if (wcnt == WLAST) begin
                        wcnt_nx  = '0;
                        pass_nx  = '0;
                        wait_nx  = '0;
                        state_nx = PRIME;
                    end else begin
                        wcnt_nx  = wcnt + WCW'(1);
                        state_nx = LOAD;
                    end
                end
            end
            PRIME: begin
                wait_nx  = '0;
                pass_nx  = '0;
                state_nx = SORT;
            end
            SORT: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_nx = '0;
                    pass_nx = pass_cnt + 4'd1;
                    if (pass_cnt + 4'd1 == PASS_LAST) state_nx = SETTLE;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            SETTLE: begin
                if (wait_cnt == WAIT_LAST) begin
                    wait_nx  = '0;
                    wcnt_nx  = '0;
                    capture  = 1'b1;
                    state_nx = DRAIN;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (m_hs) begin
                    if (wcnt == WLAST) begin
                        wcnt_nx  = '0;
                        state_nx = IDLE;
                    end else begin
                        wcnt_nx = wcnt + WCW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // trans and s_ready are registered, so they are predicted from the next state
        trans_nx = (state_nx == PRIME) || ((state_nx == SORT) && (wait_nx == WAIT_LAST));
        ready_nx = (state_nx == IDLE) || (state_nx == LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            pass_cnt   <= '0;
            wait_cnt   <= '0;
            s_ready    <= 1'b0;
            sort_trans <= 1'b0;
            frame_out  <= '0;
            cap_buf    <= '0;
        end else begin
            state      <= state_nx;
            wcnt       <= wcnt_nx;
            pass_cnt   <= pass_nx;
            wait_cnt   <= wait_nx;
            s_ready    <= ready_nx;
            sort_trans <= trans_nx;
            if (s_hs) frame_out[int'(wcnt)*DW +: DW] <= s_data;
            if (capture) cap_buf <= frame_in;
        end
    end

    always_comb begin
        sort_en    = (state == PRIME) || (state == SORT) || (state == SETTLE);
        sort_start = (state == PRIME);
        sort_dir   = '0;
        if (sort_en) sort_dir = pass_cnt[0] ? '0 : SNAKE;
        m_valid    = (state == DRAIN);
        m_data     = m_valid ? cap_buf[int'(wcnt)*DW +: DW] : '0;
        m_last     = m_valid && (wcnt == WLAST);
        busy       = (state != IDLE);
    end

`ifdef MDSA_STREAM_CTRL_CYCLE_CNT_EN
    logic [15:0] cyc_cnt;

    // Cleared as PRIME is entered, so the value read in DRAIN/IDLE is the last frame's sort time
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if ((state_nx == PRIME) && (state != PRIME)) begin
            cyc_cnt <= '0;
        end else if (sort_en && (cyc_cnt != 16'hFFFF)) begin
            cyc_cnt <= cyc_cnt + 16'd1;
        end
    end

    assign sort_cycles = cyc_cnt;
`endif

endmodule

// File: tb/tb_mdsa_stream_ctrl.sv
// Scoreboard bench for mdsa_stream_ctrl with a behavioural stand-in for the sorter core.
`timescale 1ns/1ps
module tb_mdsa_stream_ctrl;

    localparam int N        = 8;
    localparam int DW       = 32;
    localparam int NN       = N * N;
    localparam int PASSES   = 4;
    localparam int SORT_LAT = 6;
    localparam int LATENCY  = 1 + PASSES * SORT_LAT + SORT_LAT + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DW-1:0]     s_data = '0;
    logic [NN*DW-1:0]  frame_out, frame_in;
    logic              sort_en, sort_start, sort_trans;
    logic [N-1:0]      sort_dir;
    logic              m_valid, m_last, busy;
    logic              m_ready = 1'b1;
    logic [DW-1:0]     m_data;
`ifdef MDSA_STREAM_CTRL_CYCLE_CNT_EN
    logic [15:0]       sort_cycles;
`endif

    int errors = 0;
    int checks = 0;

    mdsa_stream_ctrl #(.N(N), .DW(DW), .PASSES(PASSES), .SORT_LAT(SORT_LAT)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .frame_out(frame_out),
        .sort_en(sort_en), .sort_start(sort_start), .sort_trans(sort_trans), .sort_dir(sort_dir),
        .frame_in(frame_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy)
`ifdef MDSA_STREAM_CTRL_CYCLE_CNT_EN
        , .sort_cycles(sort_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Core stand-in: a transpose plus a direction-dependent offset per feedback pass
    function automatic logic [NN*DW-1:0] core_step(input logic [NN*DW-1:0] b, input logic [N-1:0] d);
        logic [NN*DW-1:0] r;
        int row, col;
        r = '0;
        for (int k = 0; k < NN; k++) begin
            row = k / N;
            col = k % N;
            r[k*DW +: DW] = b[(col*N+row)*DW +: DW] + (d[row] ? 32'h100 : 32'h1);
        end
        return r;
    endfunction

    logic [NN*DW-1:0] core_bank = '0;
    always @(posedge clk) begin
        if (sort_trans) core_bank <= sort_start ? frame_out : core_step(core_bank, sort_dir);
    end
    assign frame_in = core_bank;

    logic [DW-1:0] cur_words [NN];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] held_data;
    logic [DW-1:0] exp_w;
    int  cyc = 0;
    int  trans_cnt = 0, prime_cnt = 0, last_trans = 0, last_in_cyc = 0, out_cnt = 0, exp_idx = 0;
    bit  seen_valid = 0, held = 0, bp_mode = 0;
    logic [3:0] bp_pat = 4'b1001;
    int  bp_ph = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            held = 0;
        end else begin
            if (sort_trans) begin
                checkOutput("trans_sort_en", sort_en, 1);
                if (trans_cnt > 0) checkOutput("trans_gap_ok", 64'(cyc - last_trans >= SORT_LAT), 1);
                if (sort_start) begin
                    prime_cnt++;
                    checkOutput("prime_is_first", trans_cnt, 0);
                    for (int k = 0; k < NN; k++)
                        checkOutput("frame_out_slot", frame_out[k*DW +: DW], cur_words[k]);
                end else begin
                    checkOutput("sort_dir", sort_dir, ((trans_cnt - 1) % 2 == 0) ? 8'hAA : 8'h00);
                end
                trans_cnt++;
                last_trans = cyc;
            end
            if (s_valid && s_ready) last_in_cyc = cyc;
            if (m_valid && !seen_valid) begin
                seen_valid = 1;
                checkOutput("latency", cyc - last_in_cyc, LATENCY);
            end
            if (held) begin
                checkOutput("hold_valid", m_valid, 1);
                checkOutput("hold_data", m_data, held_data);
            end
            held      = m_valid && !m_ready;
            held_data = m_data;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word", 1, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    checkOutput("m_data", m_data, exp_w);
                    checkOutput("m_last", m_last, 64'(exp_idx == NN - 1));
                    exp_idx = (exp_idx + 1) % NN;
                end
                out_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                m_ready = bp_pat[bp_ph];
                bp_ph   = (bp_ph + 1) % 4;
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input int nwords);
        logic [NN*DW-1:0] b;
        int guard;
        if (nwords == NN) begin
            for (int k = 0; k < NN; k++) b[k*DW +: DW] = cur_words[k];
            for (int p = 0; p < PASSES; p++) b = core_step(b, (p % 2 == 0) ? 8'hAA : 8'h00);
            for (int k = 0; k < NN; k++) exp_q.push_back(b[k*DW +: DW]);
        end
        for (int i = 0; i < nwords; i++) begin
            s_valid = 1'b1;
            s_data  = cur_words[i];
            guard   = 0;
            @(negedge clk);
            while (!s_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!s_ready) checkOutput("s_ready_timeout", 0, 1);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic runFrame(input bit backpressure);
        int g;
        trans_cnt  = 0;
        prime_cnt  = 0;
        out_cnt    = 0;
        exp_idx    = 0;
        seen_valid = 0;
        bp_mode    = backpressure;
        applyStimulus(NN);
        g = 0;
        while (out_cnt < NN && g < 3000) begin
            @(posedge clk);
            g++;
        end
        if (out_cnt < NN) checkOutput("drain_timeout", out_cnt, NN);
        @(posedge clk);
        #1;
        bp_mode = 0;
        checkOutput("trans_pulses", trans_cnt, 1 + PASSES);
        checkOutput("prime_cycles", prime_cnt, 1);
        checkOutput("out_words", out_cnt, NN);
        checkOutput("queue_empty", exp_q.size(), 0);
        checkOutput("idle_busy", busy, 0);
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_sort_en", sort_en, 0);
        checkOutput("rst_sort_trans", sort_trans, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_frame_out", 64'(frame_out != '0), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("s_ready_after_rst", s_ready, 1);

        // Abort a partially loaded frame
        for (int k = 0; k < NN; k++) cur_words[k] = 32'hA000_0000 + k;
        applyStimulus(20);
        checkOutput("busy_in_load", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_s_ready", s_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_s_ready_after", s_ready, 1);
        checkOutput("abort_busy_after", busy, 0);

        for (int k = 0; k < NN; k++) cur_words[k] = k;
        runFrame(0);
`ifdef MDSA_STREAM_CTRL_CYCLE_CNT_EN
        checkOutput("sort_cycles", sort_cycles, 1 + PASSES * SORT_LAT + SORT_LAT);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("sort_cycles_hold", sort_cycles, 1 + PASSES * SORT_LAT + SORT_LAT);
`endif

        for (int k = 0; k < NN; k++) cur_words[k] = NN - 1 - k;
        runFrame(1);
`ifdef MDSA_STREAM_CTRL_CYCLE_CNT_EN
        checkOutput("sort_cycles_frame2", sort_cycles, 1 + PASSES * SORT_LAT + SORT_LAT);
`endif

        for (int k = 0; k < NN; k++) cur_words[k] = $urandom;
        runFrame(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
